// File: rtl/route_checker.sv
// Post-route checker: reads the routed 8x8 grid and terminal list from the shared
// router SRAM, flood-fills from the first terminal and classifies the result.
module route_checker #(
    parameter int                DATA_WIDTH   = 8,
    parameter int                ADDR_WIDTH   = 8,
    parameter int                GRID_CELLS   = 64,
    parameter logic [7:0]        TERM_BASE    = 8'h80,
    parameter int                MAX_TERMINAL = 8,
    parameter logic [7:0]        NET_CODE     = 8'h00,
    parameter logic [7:0]        TERM_CODE    = 8'hEE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  cs,
    output logic                  we,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [1:0]            fail_code,
    output logic [6:0]            wire_len,
    output logic [3:0]            term_cnt
);

    // state    | meaning
    // IDLE     | waiting for start after reset
    // RD_GRID  | streaming grid cells 0..63 into the net bitmap
    // RD_TERM  | streaming terminal list until terminator or MAX_TERMINAL
    // FLOOD    | growing reach bitmap one neighbour step per cycle
    // CHECK    | classifying the result
    // DONE     | results held, start reruns
    typedef enum logic [2:0] {
        S_IDLE, S_RD_GRID, S_RD_TERM, S_FLOOD, S_CHECK, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] GRID_LAST  = ADDR_WIDTH'(GRID_CELLS - 1);
    localparam logic [DATA_WIDTH-1:0] GRID_LIMIT = DATA_WIDTH'(GRID_CELLS);
    localparam logic [2:0]            TERM_LAST  = 3'(MAX_TERMINAL - 1);
    localparam logic [63:0]           COL0_MASK  = 64'h0101_0101_0101_0101;
    localparam logic [63:0]           COL7_MASK  = 64'h8080_8080_8080_8080;
    localparam logic [63:0]           ONE64      = 64'd1;

    state_t       r_state, w_state_n;
    logic         r_vld;
    logic [5:0]   r_cnt;
    logic [2:0]   r_tidx;
    logic [5:0]   r_term0;
    logic         r_term_off;
    logic [63:0]  r_net;
    logic [63:0]  r_tmask;
    logic [63:0]  r_reach;
    logic [6:0]   r_step;

    logic         w_start_ok;
    logic         w_grid_last;
    logic         w_tvalid;
    logic         w_term_cap;
    logic         w_term_end;
    logic [3:0]   w_tcnt_n;
    logic [63:0]  w_reach_n;
    logic         w_flood_end;

    assign we = 1'b0;

    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_grid_last = (r_state == S_RD_GRID) && r_vld && (r_cnt == 6'd63);
    assign w_tvalid    = (data_in < GRID_LIMIT);
    assign w_term_cap  = (r_state == S_RD_TERM) && r_vld;
    assign w_term_end  = w_term_cap && (!w_tvalid || r_tidx == TERM_LAST);
    assign w_tcnt_n    = term_cnt + {3'b000, w_tvalid};

    // West/east shifts are masked so a path cannot wrap between col 7 and col 0.
    assign w_reach_n = r_reach | (r_net & (((r_reach >> 1) & ~COL7_MASK) |
                                           ((r_reach << 1) & ~COL0_MASK) |
                                           (r_reach >> 8) | (r_reach << 8)));
    assign w_flood_end = (w_reach_n == r_reach) || (r_step == 7'd64);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:    if (w_start_ok) w_state_n = S_RD_GRID;
            S_RD_GRID: if (w_grid_last) w_state_n = S_RD_TERM;
            S_RD_TERM: if (w_term_end) w_state_n = (w_tcnt_n == 4'd0) ? S_DONE : S_FLOOD;
            S_FLOOD:   if (w_flood_end) w_state_n = S_CHECK;
            S_CHECK:   w_state_n = S_DONE;
            S_DONE:    if (w_start_ok) w_state_n = S_RD_GRID;
            default:   w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            address    <= '0;
            cs         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_code  <= 2'd0;
            wire_len   <= 7'd0;
            term_cnt   <= 4'd0;
            r_vld      <= 1'b0;
            r_cnt      <= 6'd0;
            r_tidx     <= 3'd0;
            r_term0    <= 6'd0;
            r_term_off <= 1'b0;
            r_net      <= '0;
            r_tmask    <= '0;
            r_reach    <= '0;
            r_step     <= 7'd0;
        end else begin
            r_vld <= cs;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        address    <= '0;
                        cs         <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_code  <= 2'd0;
                        wire_len   <= 7'd0;
                        term_cnt   <= 4'd0;
                        r_cnt      <= 6'd0;
                        r_tidx     <= 3'd0;
                        r_term0    <= 6'd0;
                        r_term_off <= 1'b0;
                        r_net      <= '0;
                        r_tmask    <= '0;
                        r_reach    <= '0;
                        r_step     <= 7'd0;
                    end
                end
                S_RD_GRID: begin
                    address <= (address == GRID_LAST) ? ADDR_WIDTH'(TERM_BASE) : address + 1'b1;
                    if (r_vld) begin
                        r_net[r_cnt] <= (data_in == NET_CODE) || (data_in == TERM_CODE);
                        if (data_in == NET_CODE) wire_len <= wire_len + 7'd1;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_RD_TERM: begin
                    if (w_term_cap) begin
                        r_tidx <= r_tidx + 3'd1;
                        if (w_tvalid) begin
                            r_tmask[data_in[5:0]] <= 1'b1;
                            term_cnt <= w_tcnt_n;
                            if (r_tidx == 3'd0) r_term0 <= data_in[5:0];
                            if (!r_net[data_in[5:0]]) r_term_off <= 1'b1;
                        end
                        if (w_term_end) begin
                            cs <= 1'b0;
                            if (w_tcnt_n == 4'd0) begin
                                busy <= 1'b0;
                                done <= 1'b1;
                                pass <= 1'b1;
                            end else begin
                                // The list can only end at index >= 1 when non-empty,
                                // so terminal[0] is already registered.
                                r_reach <= (ONE64 << r_term0) & r_net;
                            end
                        end else begin
                            address <= address + 1'b1;
                        end
                    end
                end
                S_FLOOD: begin
                    r_step <= r_step + 7'd1;
                    if (!w_flood_end) r_reach <= w_reach_n;
                end
                S_CHECK: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (r_term_off)                        fail_code <= 2'd1;
                    else if ((r_tmask & ~r_reach) != '0)   fail_code <= 2'd2;
                    else if ((r_net & ~r_reach) != '0)     fail_code <= 2'd3;
                    else                                   pass      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
